motoro3_gate_driver: RTL and testbench
======================================

// Module: motoro3_gate_driver
// PURPOSE
//  Downstream of the 3-phase commutation state machine. Converts its per-phase enable/high-low
//  requests (xE, xH1_L0) plus the chopping pwm into six registered gate commands.
//  Enforces dead time on every high/low side swap and never lets both switches of a phase conduct.
//  Latches external over-current faults and illegal command patterns, forcing all gates off.
// PARAMETERS
//  DEAD_CYC  20  dead-time in clk cycles (2.0 us @ 10 MHz); legal range 1..255
//  DW        8   width of the per-phase dead-time counter
//  FCNT_W    16  fault event counter width (used only with MOTORO3_FLT_CNT_EN)
// PORTS
//  clk       in   1       10 MHz system clock; all flops on posedge
//  rst       in   1       asynchronous reset, active-high
//  en        in   1       gate enable; 0 forces every phase request to OFF
//  pwm       in   1       chopping signal; gates the high side only
//  aE,bE,cE  in   1 each  phase enable from commutation state machine
//  aH1_L0,bH1_L0,cH1_L0  in  1 each  1 = high side requested, 0 = low side
//  flt       in   1       external over-current, active-high, asynchronous to clk
//  flt_clr   in   1       single-cycle fault clear request
//  aHs,aLs,bHs,bLs,cHs,cLs  out  1 each  gate commands, 1 = switch on
//  flt_lat   out  1       sticky fault flag
//  flt_src   out  2       bit0 external flt, bit1 command error; sticky until cleared
//  flt_cnt   out  FCNT_W  saturating count of fault-latch events (macro only)
// BEHAVIOUR
//  Reset: all gates 0, flt_lat 0, flt_src 0, flt_cnt 0, all phase FSMs IDLE, dcnt 0, last_side LS.
//  Stage 1: inputs, pwm and en are registered. flt passes through a 2-flop synchroniser.
//  Per-phase request (from registered values):
//   HS if en & E & H & pwm; LS if en & E & ~H; otherwise OFF.
//  Per-phase FSM {IDLE, HS, LS}, with dcnt[DW-1:0] and last_side:
//   HS/LS -> IDLE immediately when the request differs. Load dcnt = DEAD_CYC and set last_side.
//   IDLE -> requested side when dcnt == 0, or when the requested side == last_side (re-entry, no wait).
//   IDLE with dcnt != 0 decrements by 1 per cycle and saturates at 0.
//   Direct HS <-> LS transitions are not permitted.
//  Gates are registered decodes of the state: xHs = (st == HS), xLs = (st == LS).
//  Latency: 2 clk from input change to gate change.
//  Opposite-side turn-on follows turn-off by exactly DEAD_CYC + 1 clk.
//  Command error: more than one phase requesting HS, or more than one requesting LS, in the same cycle.
//  Fault set (synced flt rising edge, or command error):
//   flt_lat = 1 and the matching flt_src bit is set (OR-accumulated).
//   On the next edge all FSMs go IDLE with dcnt = DEAD_CYC, so gates are 0 within 1 clk of the latch.
//  While flt_lat = 1: requests are ignored and all gates stay 0.
//  flt_clr: clears flt_lat and flt_src only when synced flt = 0 and no command error is present.
//   Otherwise it is ignored. Set wins over a simultaneous clear.
//  Invariant: xHs & xLs is never 1, including across reset release and fault entry/exit.
// CONFIGURATION
//  MOTORO3_FLT_CNT_EN defined:
//   flt_cnt increments on each 0->1 transition of flt_lat and saturates at all-ones.
//   It is cleared only by rst.
//  Undefined: no counter logic; flt_cnt is tied to 0.
// STRUCTURE
//  Shared include motoro3_defs.vh: phase state encodings (ST_IDLE/ST_HS/ST_LS),
//  side encodings, and the default DEAD_CYC constant.
//  Sub-module motoro3_deadtime_phase: one FSM + dcnt + last_side, instantiated 3x.
//  Top level holds the input registers, flt synchroniser, command-error check, fault latch and counter.
// TESTING
//  1 Assert rst mid-run -> all gates 0 immediately; flt_lat = 0, flt_src = 0; after release, no gate for >= 2 clk.
//  2 aE=1, aH1_L0=1, pwm=1 -> aHs=1 after 2 clk. Switch aH1_L0 to 0 -> aHs=0 after 2 clk, aLs=1 exactly 21 clk later.
//  3 aE=1, aH1_L0=1, pwm toggling 5 on / 5 off -> aHs follows with 2 clk latency and no dead wait; aLs stays 0.
//  4 flt high for 3 clk while aHs=1 -> gates 0 within 4 clk, flt_lat=1, flt_src=01.
//    flt_clr while flt=1 is ignored. After flt=0, flt_clr clears; next turn-on obeys dcnt.
//  5 aE=bE=1 with aH1_L0=bH1_L0=1 -> command error: flt_src=10, all gates 0.
//  6 MOTORO3_FLT_CNT_EN: 3 separate fault/clear cycles -> flt_cnt=3. Without the macro, flt_cnt=0.
//  All tests: assertion that no phase ever has xHs & xLs = 1 and that swap gaps are >= DEAD_CYC.

Source files
------------

// File: rtl/motoro3_gate_driver_pkg.sv
// motoro3_gate_driver_pkg
//   Shared definitions for the 3-phase gate driver:
//   - phase FSM state encoding (ST_IDLE / ST_HS / ST_LS)
//   - side encoding remembered across an IDLE gap (SIDE_LS / SIDE_HS)
//   - per-phase request encoding (REQ_OFF / REQ_HS / REQ_LS)
//   - default dead time (DEAD_CYC_DEF, clk cycles)
//   - phase_req(): maps the registered enable/side/pwm bits onto a request
package motoro3_gate_driver_pkg;

  // 20 cycles = 2.0 us at 10 MHz.
  localparam int DEAD_CYC_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HS   = 2'd1,
    ST_LS   = 2'd2
  } phase_st_t;

  typedef enum logic {
    SIDE_LS = 1'b0,
    SIDE_HS = 1'b1
  } side_t;

  typedef enum logic [1:0] {
    REQ_OFF = 2'd0,
    REQ_HS  = 2'd1,
    REQ_LS  = 2'd2
  } req_t;

  // pwm chops the high side only; the low side is held for the whole
  // commutation step so the motor current can recirculate.
  function automatic req_t phase_req(input logic en, input logic e,
                                     input logic h, input logic pwm);
    req_t r;
    r = REQ_OFF;
    if (en && e && h && pwm) begin
      r = REQ_HS;
    end else if (en && e && !h) begin
      r = REQ_LS;
    end
    return r;
  endfunction

endpackage

// File: rtl/motoro3_deadtime_phase.sv
// motoro3_deadtime_phase
//   One half-bridge leg: FSM {IDLE, HS, LS} with a dead-time counter and the
//   side that was last driven.  A leg always passes through IDLE between the
//   two sides; the opposite side may only be entered once dcnt has run out,
//   while re-entering the side that was just left needs no wait.
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   req        requested side (REQ_OFF / REQ_HS / REQ_LS)
//   force_off  fault active: go IDLE and hold dcnt at DEAD_CYC
//   hs, ls     registered gate commands
//   st         current FSM state (debug)
module motoro3_deadtime_phase
  import motoro3_gate_driver_pkg::*;
#(
  parameter int DEAD_CYC = DEAD_CYC_DEF,
  parameter int DW       = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  req_t      req,
  input  logic      force_off,
  output logic      hs,
  output logic      ls,
  output phase_st_t st
);

  localparam logic [DW-1:0] DEAD_LD = DW'(DEAD_CYC);

  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_n;
  side_t         last_side;
  side_t         last_n;
  phase_st_t     st_n;
  logic          hs_n;
  logic          ls_n;

  // State register.  Gates are registered from the next-state decode so a
  // gate flop always changes on the same edge as the state it reflects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      dcnt      <= '0;
      last_side <= SIDE_LS;
      hs        <= 1'b0;
      ls        <= 1'b0;
    end else begin
      st        <= st_n;
      dcnt      <= dcnt_n;
      last_side <= last_n;
      hs        <= hs_n;
      ls        <= ls_n;
    end
  end

  // Next-state logic.
  always_comb begin
    st_n   = st;
    dcnt_n = dcnt;
    last_n = last_side;
    if (force_off) begin
      // Held at full dead time for as long as the fault lasts, so the first
      // opposite-side turn-on after the clear still waits the full gap.
      st_n   = ST_IDLE;
      dcnt_n = DEAD_LD;
      if (st == ST_HS) last_n = SIDE_HS;
      if (st == ST_LS) last_n = SIDE_LS;
    end else begin
      case (st)
        ST_HS: begin
          if (req != REQ_HS) begin
            st_n   = ST_IDLE;
            dcnt_n = DEAD_LD;
            last_n = SIDE_HS;
          end
        end
        ST_LS: begin
          if (req != REQ_LS) begin
            st_n   = ST_IDLE;
            dcnt_n = DEAD_LD;
            last_n = SIDE_LS;
          end
        end
        default: begin
          if (req == REQ_HS && (dcnt == '0 || last_side == SIDE_HS)) begin
            st_n = ST_HS;
          end else if (req == REQ_LS && (dcnt == '0 || last_side == SIDE_LS)) begin
            st_n = ST_LS;
          end else if (dcnt != '0) begin
            dcnt_n = dcnt - DW'(1);
          end
        end
      endcase
    end
  end

  // Output decode of the next state.
  always_comb begin
    hs_n = (st_n == ST_HS);
    ls_n = (st_n == ST_LS);
  end

endmodule

// File: rtl/motoro3_gate_driver.sv
// motoro3_gate_driver
//   Turns the commutation state machine's per-phase enable / side requests
//   and the chopping pwm into six registered gate commands with dead time,
//   and latches over-current and illegal-command faults (all gates off).
//   Optional macro: MOTORO3_FLT_CNT_EN adds a saturating fault-event counter
//   on flt_cnt; without it flt_cnt is tied to 0.
// Ports
//   clk, rst                 10 MHz clock, asynchronous active-high reset
//   en                       gate enable (0 = all phases OFF)
//   pwm                      chopping signal, high side only
//   aE/bE/cE                 phase enables
//   aH1_L0/bH1_L0/cH1_L0     1 = high side, 0 = low side
//   flt                      external over-current, asynchronous, active-high
//   flt_clr                  single-cycle fault clear request
//   aHs..cLs                 gate commands, 1 = switch on
//   flt_lat                  sticky fault flag
//   flt_src                  bit0 external fault, bit1 command error (sticky)
//   flt_cnt                  fault-latch event count (macro build only)
//   dbg_st                   {c, b, a} phase FSM states, 2 bits each
module motoro3_gate_driver
  import motoro3_gate_driver_pkg::*;
#(
  parameter int DEAD_CYC = DEAD_CYC_DEF,
  parameter int DW       = 8,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pwm,
  input  logic              aE,
  input  logic              bE,
  input  logic              cE,
  input  logic              aH1_L0,
  input  logic              bH1_L0,
  input  logic              cH1_L0,
  input  logic              flt,
  input  logic              flt_clr,
  output logic              aHs,
  output logic              aLs,
  output logic              bHs,
  output logic              bLs,
  output logic              cHs,
  output logic              cLs,
  output logic              flt_lat,
  output logic [1:0]        flt_src,
  output logic [FCNT_W-1:0] flt_cnt,
  output logic [5:0]        dbg_st
);

  // Stage 1: input registers and flt synchroniser.
  logic       en_q;
  logic       pwm_q;
  logic [2:0] e_q;
  logic [2:0] h_q;
  logic       flt_s1;
  logic       flt_s2;
  logic       flt_s2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      pwm_q    <= 1'b0;
      e_q      <= '0;
      h_q      <= '0;
      flt_s1   <= 1'b0;
      flt_s2   <= 1'b0;
      flt_s2_d <= 1'b0;
    end else begin
      en_q     <= en;
      pwm_q    <= pwm;
      e_q      <= {cE, bE, aE};
      h_q      <= {cH1_L0, bH1_L0, aH1_L0};
      flt_s1   <= flt;
      flt_s2   <= flt_s1;
      flt_s2_d <= flt_s2;
    end
  end

  // Per-phase requests and command-error check.
  req_t       req [3];
  logic [2:0] hs_req;
  logic [2:0] ls_req;
  logic       cmd_err;
  logic       flt_rise;
  logic       fault_set;
  logic       clr_ok;
  logic       force_off;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      req[i]    = phase_req(en_q, e_q[i], h_q[i], pwm_q);
      hs_req[i] = (req[i] == REQ_HS);
      ls_req[i] = (req[i] == REQ_LS);
    end
  end

  always_comb begin
    // v & (v - 1) is non-zero exactly when more than one bit of v is set.
    cmd_err   = (|(hs_req & (hs_req - 3'd1))) | (|(ls_req & (ls_req - 3'd1)));
    flt_rise  = flt_s2 & ~flt_s2_d;
    fault_set = flt_rise | cmd_err;
    clr_ok    = flt_clr & ~flt_s2 & ~cmd_err;
    // fault_set is included so an illegal pattern never reaches the gates,
    // not even for the one cycle before flt_lat is set.
    force_off = flt_lat | fault_set;
  end

  // Fault latch: a new set always wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_lat <= 1'b0;
      flt_src <= 2'b00;
    end else if (fault_set) begin
      flt_lat <= 1'b1;
      flt_src <= flt_src | {cmd_err, flt_rise};
    end else if (clr_ok) begin
      flt_lat <= 1'b0;
      flt_src <= 2'b00;
    end
  end

`ifdef MOTORO3_FLT_CNT_EN
  logic [FCNT_W-1:0] cnt;

  // Counts 0->1 transitions of flt_lat; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (fault_set && !flt_lat && cnt != '1) begin
      cnt <= cnt + FCNT_W'(1);
    end
  end

  assign flt_cnt = cnt;
`else
  assign flt_cnt = '0;
`endif

  // Three dead-time legs.
  logic [2:0] hs_o;
  logic [2:0] ls_o;
  phase_st_t  st_o [3];

  for (genvar i = 0; i < 3; i++) begin : g_ph
    motoro3_deadtime_phase #(
      .DEAD_CYC (DEAD_CYC),
      .DW       (DW)
    ) u_ph (
      .clk       (clk),
      .rst       (rst),
      .req       (req[i]),
      .force_off (force_off),
      .hs        (hs_o[i]),
      .ls        (ls_o[i]),
      .st        (st_o[i])
    );
  end

  assign aHs    = hs_o[0];
  assign aLs    = ls_o[0];
  assign bHs    = hs_o[1];
  assign bLs    = ls_o[1];
  assign cHs    = hs_o[2];
  assign cLs    = ls_o[2];
  assign dbg_st = {st_o[2], st_o[1], st_o[0]};

endmodule

// File: tb/tb_motoro3_gate_driver.sv
// tb_motoro3_gate_driver
//   Scenario tasks drive the gate driver and compare gate vectors
//   {aHs,aLs,bHs,bLs,cHs,cLs} against an expected queue, plus inline checks of
//   the fault flags.  Every clock tick also checks that no leg drives both
//   switches and that side swaps are separated by at least DEAD_CYC cycles.
module tb_motoro3_gate_driver;

  localparam int DEAD_CYC = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pwm;
  logic        aE, bE, cE;
  logic        aH, bH, cH;
  logic        flt;
  logic        flt_clr;
  logic        aHs, aLs, bHs, bLs, cHs, cLs;
  logic        flt_lat;
  logic [1:0]  flt_src;
  logic [15:0] flt_cnt;
  logic [5:0]  dbg_st;

  logic [5:0]  gates;
  logic [5:0]  exp_g;
  logic [5:0]  exp_q[$];
  logic [15:0] exp_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Swap-gap tracking per leg.
  int   off_cyc [3];
  logic off_hs  [3];
  logic off_vld [3];
  logic prev_hs [3];
  logic prev_ls [3];

  assign gates = {aHs, aLs, bHs, bLs, cHs, cLs};

  // 10 MHz clock.
  always #50 clk = ~clk;

  motoro3_gate_driver #(
    .DEAD_CYC (DEAD_CYC),
    .DW       (8),
    .FCNT_W   (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pwm     (pwm),
    .aE      (aE),
    .bE      (bE),
    .cE      (cE),
    .aH1_L0  (aH),
    .bH1_L0  (bH),
    .cH1_L0  (cH),
    .flt     (flt),
    .flt_clr (flt_clr),
    .aHs     (aHs),
    .aLs     (aLs),
    .bHs     (bHs),
    .bLs     (bLs),
    .cHs     (cHs),
    .cLs     (cLs),
    .flt_lat (flt_lat),
    .flt_src (flt_src),
    .flt_cnt (flt_cnt),
    .dbg_st  (dbg_st)
  );

  // One clock: sample 1 ns after the edge and run the leg safety checks.
  task automatic tick();
    logic [1:0] ph [3];
    @(posedge clk);
    #1;
    cyc++;
    ph[0] = {aHs, aLs};
    ph[1] = {bHs, bLs};
    ph[2] = {cHs, cLs};
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (ph[i] === 2'b11) begin
        n_err++;
        $display("FAIL overlap leg %0d: hs=1 ls=1 at cycle %0d, required never both", i, cyc);
      end
      if (rst) begin
        off_vld[i] = 1'b0;
      end else begin
        if (prev_hs[i] && !ph[i][1]) begin
          off_vld[i] = 1'b1; off_hs[i] = 1'b1; off_cyc[i] = cyc;
        end
        if (prev_ls[i] && !ph[i][0]) begin
          off_vld[i] = 1'b1; off_hs[i] = 1'b0; off_cyc[i] = cyc;
        end
        if (ph[i][0] && !prev_ls[i] && off_vld[i] && off_hs[i]) begin
          n_vec++;
          if (cyc - off_cyc[i] < DEAD_CYC) begin
            n_err++;
            $display("FAIL gap hs->ls leg %0d: got %0d cycles, required >= %0d", i, cyc - off_cyc[i], DEAD_CYC);
          end
        end
        if (ph[i][1] && !prev_hs[i] && off_vld[i] && !off_hs[i]) begin
          n_vec++;
          if (cyc - off_cyc[i] < DEAD_CYC) begin
            n_err++;
            $display("FAIL gap ls->hs leg %0d: got %0d cycles, required >= %0d", i, cyc - off_cyc[i], DEAD_CYC);
          end
        end
      end
      prev_hs[i] = ph[i][1];
      prev_ls[i] = ph[i][0];
    end
  endtask

  task automatic test_power_on();
    tick();
    n_vec++;
    if (gates !== 6'b0) begin n_err++; $display("FAIL power_on gates: got %b, expected 000000", gates); end
    n_vec++;
    if (flt_lat !== 1'b0) begin n_err++; $display("FAIL power_on flt_lat: got %b, expected 0", flt_lat); end
    n_vec++;
    if (flt_src !== 2'b00) begin n_err++; $display("FAIL power_on flt_src: got %b, expected 00", flt_src); end
    n_vec++;
    if (flt_cnt !== 16'd0) begin n_err++; $display("FAIL power_on flt_cnt: got %0d, expected 0", flt_cnt); end
  endtask

  // High side on, then swap to low side across the dead time.
  task automatic test_hs_to_ls();
    en = 1'b1; aE = 1'b1; aH = 1'b1; pwm = 1'b1;
    exp_q.push_back(6'b000000);
    repeat (4) exp_q.push_back(6'b100000);
    while (exp_q.size() > 0) begin
      tick(); exp_g = exp_q.pop_front(); n_vec++;
      if (gates !== exp_g) begin n_err++; $display("FAIL hs_on gates: got %b, expected %b (cycle %0d)", gates, exp_g, cyc); end
    end
    aH = 1'b0;
    exp_q.push_back(6'b100000);
    repeat (DEAD_CYC + 1) exp_q.push_back(6'b000000);
    repeat (3) exp_q.push_back(6'b010000);
    while (exp_q.size() > 0) begin
      tick(); exp_g = exp_q.pop_front(); n_vec++;
      if (gates !== exp_g) begin n_err++; $display("FAIL hs_to_ls gates: got %b, expected %b (cycle %0d)", gates, exp_g, cyc); end
    end
  endtask

  // 5 on / 5 off chopping: high side follows pwm with no dead wait.
  task automatic test_pwm_chop();
    aH = 1'b1; pwm = 1'b1;
    repeat (DEAD_CYC + 5) tick();
    n_vec++;
    if (gates !== 6'b100000) begin n_err++; $display("FAIL chop_start gates: got %b, expected 100000", gates); end
    exp_q.push_back(6'b100000);
    for (int i = 0; i < 40; i++) begin
      pwm = ((i / 5) % 2 == 1);
      exp_q.push_back(pwm ? 6'b100000 : 6'b000000);
      tick(); exp_g = exp_q.pop_front(); n_vec++;
      if (gates !== exp_g) begin n_err++; $display("FAIL pwm_chop gates: got %b, expected %b (cycle %0d)", gates, exp_g, cyc); end
    end
    tick(); exp_g = exp_q.pop_front(); n_vec++;
    if (gates !== exp_g) begin n_err++; $display("FAIL pwm_chop tail gates: got %b, expected %b", gates, exp_g); end
  endtask

  // External fault while the high side conducts; clear, then swap obeys dcnt.
  task automatic test_fault_ext();
    flt = 1'b1;
    exp_q.push_back(6'b100000);
    exp_q.push_back(6'b100000);
    exp_q.push_back(6'b000000);
    while (exp_q.size() > 0) begin
      tick(); exp_g = exp_q.pop_front(); n_vec++;
      if (gates !== exp_g) begin n_err++; $display("FAIL fault_ext gates: got %b, expected %b (cycle %0d)", gates, exp_g, cyc); end
    end
    exp_cnt = exp_cnt + 16'd1;
    n_vec++;
    if (flt_lat !== 1'b1) begin n_err++; $display("FAIL fault_ext flt_lat: got %b, expected 1", flt_lat); end
    n_vec++;
    if (flt_src !== 2'b01) begin n_err++; $display("FAIL fault_ext flt_src: got %b, expected 01", flt_src); end
    flt = 1'b0; flt_clr = 1'b1; aH = 1'b0;
    tick();
    flt_clr = 1'b0;
    n_vec++;
    if (flt_lat !== 1'b1) begin n_err++; $display("FAIL fault_ext clr_while_flt flt_lat: got %b, expected 1", flt_lat); end
    repeat (3) tick();
    flt_clr = 1'b1;
    tick();
    flt_clr = 1'b0;
    n_vec++;
    if (flt_lat !== 1'b0) begin n_err++; $display("FAIL fault_ext clear flt_lat: got %b, expected 0", flt_lat); end
    n_vec++;
    if (flt_src !== 2'b00) begin n_err++; $display("FAIL fault_ext clear flt_src: got %b, expected 00", flt_src); end
    repeat (DEAD_CYC) exp_q.push_back(6'b000000);
    exp_q.push_back(6'b010000);
    while (exp_q.size() > 0) begin
      tick(); exp_g = exp_q.pop_front(); n_vec++;
      if (gates !== exp_g) begin n_err++; $display("FAIL fault_exit gates: got %b, expected %b (cycle %0d)", gates, exp_g, cyc); end
    end
  endtask

  // Two phases asking for the high side together.
  task automatic test_cmd_err();
    aH = 1'b1; bE = 1'b1; bH = 1'b1;
    exp_q.push_back(6'b010000);
    repeat (3) exp_q.push_back(6'b000000);
    while (exp_q.size() > 0) begin
      tick(); exp_g = exp_q.pop_front(); n_vec++;
      if (gates !== exp_g) begin n_err++; $display("FAIL cmd_err gates: got %b, expected %b (cycle %0d)", gates, exp_g, cyc); end
    end
    exp_cnt = exp_cnt + 16'd1;
    n_vec++;
    if (flt_lat !== 1'b1) begin n_err++; $display("FAIL cmd_err flt_lat: got %b, expected 1", flt_lat); end
    n_vec++;
    if (flt_src !== 2'b10) begin n_err++; $display("FAIL cmd_err flt_src: got %b, expected 10", flt_src); end
    flt_clr = 1'b1;
    tick();
    flt_clr = 1'b0;
    n_vec++;
    if (flt_lat !== 1'b1) begin n_err++; $display("FAIL cmd_err clr_while_err flt_lat: got %b, expected 1", flt_lat); end
    bE = 1'b0;
    tick();
    flt_clr = 1'b1;
    tick();
    flt_clr = 1'b0;
    n_vec++;
    if (flt_lat !== 1'b0) begin n_err++; $display("FAIL cmd_err clear flt_lat: got %b, expected 0", flt_lat); end
    n_vec++;
    if (flt_src !== 2'b00) begin n_err++; $display("FAIL cmd_err clear flt_src: got %b, expected 00", flt_src); end
  endtask

  // Reset asserted mid-cycle with the high side on.
  task automatic test_reset();
    repeat (DEAD_CYC + 5) tick();
    n_vec++;
    if (gates !== 6'b100000) begin n_err++; $display("FAIL reset_pre gates: got %b, expected 100000", gates); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_cnt = 16'd0;
    n_vec++;
    if (gates !== 6'b0) begin n_err++; $display("FAIL reset gates: got %b, expected 000000", gates); end
    n_vec++;
    if (flt_lat !== 1'b0) begin n_err++; $display("FAIL reset flt_lat: got %b, expected 0", flt_lat); end
    n_vec++;
    if (flt_src !== 2'b00) begin n_err++; $display("FAIL reset flt_src: got %b, expected 00", flt_src); end
    n_vec++;
    if (flt_cnt !== 16'd0) begin n_err++; $display("FAIL reset flt_cnt: got %0d, expected 0", flt_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(6'b000000);
    exp_q.push_back(6'b100000);
    while (exp_q.size() > 0) begin
      tick(); exp_g = exp_q.pop_front(); n_vec++;
      if (gates !== exp_g) begin n_err++; $display("FAIL reset_release gates: got %b, expected %b (cycle %0d)", gates, exp_g, cyc); end
    end
  endtask

  // Normal two-phase conduction: a high, b low.
  task automatic test_two_phase();
    bE = 1'b1; bH = 1'b0;
    exp_q.push_back(6'b100000);
    repeat (3) exp_q.push_back(6'b100100);
    while (exp_q.size() > 0) begin
      tick(); exp_g = exp_q.pop_front(); n_vec++;
      if (gates !== exp_g) begin n_err++; $display("FAIL two_phase gates: got %b, expected %b (cycle %0d)", gates, exp_g, cyc); end
    end
    n_vec++;
    if (flt_lat !== 1'b0) begin n_err++; $display("FAIL two_phase flt_lat: got %b, expected 0", flt_lat); end
  endtask

  // Three separate fault/clear cycles.
  task automatic test_fault_count();
    for (int k = 0; k < 3; k++) begin
      flt = 1'b1;
      repeat (3) tick();
      exp_cnt = exp_cnt + 16'd1;
      n_vec++;
      if (flt_lat !== 1'b1) begin n_err++; $display("FAIL fault_count[%0d] flt_lat: got %b, expected 1", k, flt_lat); end
      n_vec++;
      if (gates !== 6'b0) begin n_err++; $display("FAIL fault_count[%0d] gates: got %b, expected 000000", k, gates); end
      flt = 1'b0;
      repeat (4) tick();
      flt_clr = 1'b1;
      tick();
      flt_clr = 1'b0;
      n_vec++;
      if (flt_lat !== 1'b0) begin n_err++; $display("FAIL fault_count[%0d] clear flt_lat: got %b, expected 0", k, flt_lat); end
    end
`ifdef MOTORO3_FLT_CNT_EN
    n_vec++;
    if (flt_cnt !== exp_cnt) begin n_err++; $display("FAIL flt_cnt: got %0d, expected %0d", flt_cnt, exp_cnt); end
`else
    n_vec++;
    if (flt_cnt !== 16'd0) begin n_err++; $display("FAIL flt_cnt: got %0d, expected 0", flt_cnt); end
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pwm = 1'b0;
    aE = 1'b0; bE = 1'b0; cE = 1'b0;
    aH = 1'b0; bH = 1'b0; cH = 1'b0;
    flt = 1'b0; flt_clr = 1'b0;
    exp_cnt = 16'd0;
    for (int i = 0; i < 3; i++) begin
      off_cyc[i] = 0; off_hs[i] = 1'b0; off_vld[i] = 1'b0;
      prev_hs[i] = 1'b0; prev_ls[i] = 1'b0;
    end
    repeat (3) tick();
    rst = 1'b0;
    test_power_on();
    test_hs_to_ls();
    test_pwm_chop();
    test_fault_ext();
    test_cmd_err();
    test_reset();
    test_two_phase();
    test_fault_count();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
